// File: rtl/t0_generator.sv
// rtl/t0_generator.sv - t0 trigger generator with internal-period and external-trigger modes
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   start, stop       one-clock pulses: arm/launch and abort a sequence
//   mode              0 = internal period, 1 = external trigger
//   ext_trig          asynchronous external trigger, rising-edge sensitive
//   interval          internal-mode period in cycles (0 and 1 behave as 2)
//   holdoff           external-mode minimum t0 spacing in cycles (0 behaves as 1)
//   count             t0 pulses per sequence, 0 = unlimited
//   t0, busy, done    t0 pulse, sequence running, normal-completion pulse
//   t0_count, missed  t0 pulses issued / external edges dropped since the last start
module t0_generator #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic             ext_trig,
   input  logic [WIDTH-1:0] interval,
   input  logic [WIDTH-1:0] holdoff,
   input  logic [15:0]      count,
   output logic             t0,
   output logic             busy,
   output logic             done,
   output logic [15:0]      t0_count,
   output logic [15:0]      missed
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUN_INT = 2'd1;
   localparam logic [1:0] RUN_EXT = 2'd2;
   localparam logic [1:0] FINISH  = 2'd3;

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO_W = WIDTH'(2);

   logic [1:0]             state_q, state_d;
   logic [WIDTH-1:0]       len_m1_q, len_m1_d;
   logic [WIDTH-1:0]       tmr_q, tmr_d;
   logic [15:0]            count_q, count_d;
   logic [15:0]            t0_count_q, t0_count_d;
   logic [15:0]            missed_q, missed_d;
   logic                   t0_q, t0_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   trig_prev_q;

   logic                   edge_det;
   logic                   reached;
   logic [WIDTH-1:0]       int_len_m1;
   logic [WIDTH-1:0]       ext_len_m1;
   logic [15:0]            t0_count_inc;
   logic [15:0]            missed_inc;

   assign edge_det     = sync_q[SYNC_STAGES-1] & ~trig_prev_q;
   assign reached      = (count_q != 16'd0) && (t0_count_q == count_q);
   // One shared timer: period-1 in internal mode, holdoff-1 in external mode.
   assign int_len_m1   = (interval < TWO_W) ? ONE_W : interval - ONE_W;
   assign ext_len_m1   = (holdoff == '0) ? '0 : holdoff - ONE_W;
   assign t0_count_inc = (t0_count_q == 16'hFFFF) ? t0_count_q : t0_count_q + 16'd1;
   assign missed_inc   = (missed_q == 16'hFFFF) ? missed_q : missed_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      len_m1_d   = len_m1_q;
      tmr_d      = tmr_q;
      count_d    = count_q;
      t0_count_d = t0_count_q;
      missed_d   = missed_q;
      t0_d       = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            // stop wins over a simultaneous start
            if (start && !stop) begin
               count_d  = count;
               missed_d = '0;
               busy_d   = 1'b1;
               if (!mode) begin
                  state_d    = RUN_INT;
                  len_m1_d   = int_len_m1;
                  tmr_d      = int_len_m1;
                  t0_d       = 1'b1;
                  t0_count_d = 16'd1;
               end else begin
                  state_d    = RUN_EXT;
                  len_m1_d   = ext_len_m1;
                  tmr_d      = '0;
                  t0_count_d = '0;
               end
            end
         end
         RUN_INT: begin
            if (stop) begin
               state_d = IDLE;
            end else if (reached) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else begin
               busy_d = 1'b1;
               // reload on expiry keeps the spacing exact with no drift
               if (tmr_q == '0) begin
                  t0_d       = 1'b1;
                  t0_count_d = t0_count_inc;
                  tmr_d      = len_m1_q;
               end else begin
                  tmr_d = tmr_q - ONE_W;
               end
            end
         end
         RUN_EXT: begin
            if (stop) begin
               state_d = IDLE;
            end else begin
               if (tmr_q != '0) begin
                  tmr_d = tmr_q - ONE_W;
               end
               if (reached) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
                  if (edge_det) begin
                     missed_d = missed_inc;
                  end
               end else begin
                  busy_d = 1'b1;
                  if (edge_det) begin
                     if (tmr_q != '0) begin
                        missed_d = missed_inc;
                     end else begin
                        t0_d       = 1'b1;
                        t0_count_d = t0_count_inc;
                        tmr_d      = len_m1_q;
                     end
                  end
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         len_m1_q    <= '0;
         tmr_q       <= '0;
         count_q     <= '0;
         t0_count_q  <= '0;
         missed_q    <= '0;
         t0_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sync_q      <= '0;
         trig_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_m1_q    <= len_m1_d;
         tmr_q       <= tmr_d;
         count_q     <= count_d;
         t0_count_q  <= t0_count_d;
         missed_q    <= missed_d;
         t0_q        <= t0_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         // synchronizer runs in every state so a level already high at start is not an edge
         sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_trig};
         trig_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign t0       = t0_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign t0_count = t0_count_q;
   assign missed   = missed_q;

endmodule

// File: tb/tb_t0_generator.sv
// tb/tb_t0_generator.sv - self-checking bench for t0_generator
`timescale 1ns/1ps
module tb_t0_generator;

   localparam int W = 16;
   localparam int S = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, stop, mode, ext_trig;
   logic [W-1:0]  interval, holdoff;
   logic [15:0]   count;
   logic          t0, busy, done;
   logic [15:0]   t0_count, missed;

   int errors = 0;
   int checks = 0;

   t0_generator #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
      .ext_trig(ext_trig), .interval(interval), .holdoff(holdoff), .count(count),
      .t0(t0), .busy(busy), .done(done), .t0_count(t0_count), .missed(missed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: event timestamps (edge indices) instead of down-counters.
   bit hist [0:16383];
   int e = 0;
   int rst_edge = 0;
   int m_st = 0;                // 0 idle, 1 running, 2 finish
   bit m_mode;
   int m_p, m_h, m_cnt, m_start, m_last;
   int n_t0 = 0, n_miss = 0;
   bit x_t0 = 0, x_busy = 0, x_done = 0;

   function automatic bit smp(input int i);
      return (i >= rst_edge) ? hist[i] : 1'b0;
   endfunction

   task automatic model_edge();
      bit det;
      hist[e] = ext_trig;
      det = smp(e - S) && !smp(e - S - 1);
      x_t0 = 0;
      x_done = 0;
      case (m_st)
         0: if (start && !stop) begin
               n_t0 = 0; n_miss = 0;
               m_mode = mode;
               m_p = (interval < 2) ? 2 : int'(interval);
               m_h = (holdoff < 1) ? 1 : int'(holdoff);
               m_cnt = count;
               m_start = e;
               m_st = 1;
               if (!mode) begin x_t0 = 1; n_t0 = 1; end
               else m_last = e - m_h;
            end
         1: if (stop) m_st = 0;
            else if (m_cnt != 0 && n_t0 == m_cnt) begin
               m_st = 2; x_done = 1;
               if (m_mode && det) n_miss = (n_miss < 65535) ? n_miss + 1 : n_miss;
            end else if (!m_mode) begin
               if ((e - m_start) % m_p == 0) begin
                  x_t0 = 1; n_t0 = (n_t0 < 65535) ? n_t0 + 1 : n_t0;
               end
            end else if (det) begin
               if (e - m_last >= m_h) begin
                  x_t0 = 1; m_last = e; n_t0 = (n_t0 < 65535) ? n_t0 + 1 : n_t0;
               end else n_miss = (n_miss < 65535) ? n_miss + 1 : n_miss;
            end
         default: m_st = 0;
      endcase
      x_busy = (m_st == 1);
      e++;
   endtask

   task automatic model_reset();
      m_st = 0; n_t0 = 0; n_miss = 0; x_t0 = 0; x_busy = 0; x_done = 0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("model", {t0, busy, done, t0_count, missed},
          {x_t0, x_busy, x_done, 16'(n_t0), 16'(n_miss)});
   endtask

   typedef struct {
      int          ival;
      int          cnt;
      logic [31:0] mask;     // bit c set = t0 expected in cycle c
      int          done_c;
      int          tcount;
   } vec_t;

   vec_t vt [5];

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      vt[0] = '{10, 3, 32'h0020_0802, 22, 3};
      vt[1] = '{1,  4, 32'h0000_00AA, 8,  4};
      vt[2] = '{0,  2, 32'h0000_000A, 4,  2};
      vt[3] = '{2,  1, 32'h0000_0002, 2,  1};
      vt[4] = '{5,  3, 32'h0000_0842, 12, 3};

      reset_n = 0; start = 0; stop = 0; mode = 0; ext_trig = 0;
      interval = 0; holdoff = 0; count = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_t0", t0, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_t0_count", t0_count, 0);
      chk("reset_missed", missed, 0);
      #2 reset_n = 1;
      rst_edge = e;
      step();

      // internal-mode vectors; parameters are scrambled after start
      for (int v = 0; v < 5; v++) begin
         mode = 0; interval = W'(vt[v].ival); count = 16'(vt[v].cnt); start = 1;
         step();
         start = 0; interval = W'($urandom_range(0, 30)); count = 16'($urandom_range(0, 9));
         mode = 1'($urandom_range(0, 1));
         for (int c = 1; c <= 30; c++) begin
            chk($sformatf("vec%0d_cyc%0d", v, c), {t0, done, busy},
                {vt[v].mask[c], c == vt[v].done_c, c < vt[v].done_c});
            if (c < 30) step();
         end
         chk($sformatf("vec%0d_t0_count", v), t0_count, 16'(vt[v].tcount));
      end

      // external mode, holdoff 20, edges every 5 cycles
      mode = 1; holdoff = 20; count = 0; ext_trig = 0; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 100; i++) begin
         ext_trig = ((i % 5) < 2);
         step();
         if (i < S) chk("ext_latency_early", t0, 0);
         if (i == S) chk("ext_latency", t0, 1);
      end
      chk("ext_t0_count", t0_count, 5);
      chk("ext_missed", missed, 15);
      stop = 1;
      step();
      stop = 0;
      chk("ext_stop", {busy, done, t0_count, missed}, {1'b0, 1'b0, 16'd5, 16'd15});

      // stop sampled on a t0-due cycle
      mode = 0; interval = 8; count = 0; start = 1;
      step();
      start = 0;
      for (int c = 2; c <= 16; c++) step();
      stop = 1;
      step();
      stop = 0;
      chk("stop_due", {t0, busy, done, t0_count}, {1'b0, 1'b0, 1'b0, 16'd2});
      for (int c = 0; c < 3; c++) step();
      chk("stop_held", {done, busy, t0_count}, {1'b0, 1'b0, 16'd2});

      // start and stop together in IDLE
      start = 1; stop = 1;
      step();
      start = 0; stop = 0;
      chk("start_stop_idle", {t0, busy, t0_count}, {1'b0, 1'b0, 16'd2});
      step();
      chk("start_stop_idle2", {t0, busy}, 2'b00);

      // ext_trig already high at start is not an edge
      ext_trig = 1;
      for (int c = 0; c < S + 2; c++) step();
      mode = 1; holdoff = 3; count = 2; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 8; c++) step();
      chk("ext_level_ignored", t0_count, 0);
      ext_trig = 0; step(); step();
      ext_trig = 1;
      for (int c = 0; c <= S; c++) step();
      chk("ext_new_edge1", t0, 1);
      ext_trig = 0; step(); step();
      ext_trig = 1;
      for (int c = 0; c <= S; c++) step();
      chk("ext_new_edge2", t0, 1);
      step();
      chk("ext_done", {done, busy, t0_count}, {1'b1, 1'b0, 16'd2});
      step();
      chk("ext_done_once", done, 0);

      // reset mid RUN_EXT
      ext_trig = 0; mode = 1; holdoff = 2; count = 0; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 12; i++) begin
         ext_trig = ((i % 3) == 0);
         step();
      end
      #2 reset_n = 0;
      #1;
      chk("reset_async", {t0, busy, done, t0_count, missed}, 0);
      model_reset();
      start = 1;
      @(posedge clk); #1;
      chk("start_in_reset", {busy, t0}, 2'b00);
      #2 reset_n = 1;
      rst_edge = e;
      start = 0;
      for (int i = 0; i < 6; i++) step();
      chk("after_reset", {done, busy}, 2'b00);

      // randomized runs against the model
      for (int r = 0; r < 30; r++) begin
         mode = 1'($urandom_range(0, 1));
         interval = W'($urandom_range(0, 9));
         holdoff = W'($urandom_range(0, 12));
         count = 16'($urandom_range(0, 4));
         start = 1;
         stop = ($urandom_range(0, 7) == 0);
         step();
         start = 0; stop = 0;
         for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) == 0) ext_trig = ~ext_trig;
            mode = 1'($urandom_range(0, 1));
            interval = W'($urandom_range(0, 9));
            holdoff = W'($urandom_range(0, 12));
            count = 16'($urandom_range(0, 4));
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 39) == 0);
            step();
         end
         start = 0; stop = 1;
         step();
         stop = 0;
         step();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
